// File: rtl/flash_seq.sv
// Single-byte read/write sequencer for a parallel NOR flash, with a busy flag and an optional DQ7 poll.
// Build option: define FLASH_POLL_EN to include the poll states, timeout counter and timeout flag.
module flash_seq #(
  parameter int AW           = 19,
  parameter int SETUP_CYCLES = 1,
  parameter int ACC_CYCLES   = 3,
  parameter int TOUT_W       = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_addr,
  input  logic          wr_data,
  input  logic          rd_data,
  input  logic [7:0]    wr_buffer,
  output logic [7:0]    rd_buffer,
  input  logic          autoinc_ena,
  input  logic          poll_ena,
  output logic          busy,
  output logic          timeout,
  output logic [AW-1:0] rom_a,
  inout  wire  [7:0]    rom_d,
  output logic          rom_cs_n,
  output logic          rom_oe_n,
  output logic          rom_we_n,
  output logic [2:0]    dbg_state
);

  // Host handshake: wr_addr/wr_data/rd_data are single-cycle pulses honoured only
  // while busy=0 (priority wr_addr > wr_data > rd_data); anything seen while busy=1 is dropped.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_STROBE   = 3'd2,
    S_HOLD     = 3'd3,
    S_P_SETUP  = 3'd4,
    S_P_STROBE = 3'd5,
    S_P_CHECK  = 3'd6
  } state_t;

  localparam int CNT_MAX = (SETUP_CYCLES > ACC_CYCLES) ? SETUP_CYCLES : ACC_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] ACC_LAST   = CW'(ACC_CYCLES - 1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [AW-1:0]   addr;
  logic [7:0]      wdata;
  logic            is_wr, is_wr_n;
  logic            drive_en;
  logic            accept_wr, accept_rd, load_addr, inc_addr, capture_rd;
  logic            cs_act, oe_act, we_act, drv_act;

`ifdef FLASH_POLL_EN
  logic              poll_q;
  logic              poll_dq7;
  logic [TOUT_W-1:0] tout_cnt;
  logic              timeout_q;
  logic              capture_poll, tout_inc, tout_set;
`else
  logic [TOUT_W:0]   unused_sig;
  assign unused_sig = {TOUT_W'(0), poll_ena};
`endif

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    accept_wr  = 1'b0;
    accept_rd  = 1'b0;
    load_addr  = 1'b0;
    inc_addr   = 1'b0;
    capture_rd = 1'b0;
`ifdef FLASH_POLL_EN
    capture_poll = 1'b0;
    tout_inc     = 1'b0;
    tout_set     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (wr_addr) begin
          load_addr = 1'b1;
        end else if (wr_data) begin
          accept_wr = 1'b1;
          state_n   = S_SETUP;
          cnt_n     = '0;
        end else if (rd_data) begin
          accept_rd = 1'b1;
          state_n   = S_SETUP;
          cnt_n     = '0;
        end
      end
      S_SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_n   = '0;
          state_n = S_STROBE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_STROBE: begin
        if (cnt == ACC_LAST) begin
          cnt_n      = '0;
          state_n    = S_HOLD;
          capture_rd = ~is_wr;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_HOLD: begin
`ifdef FLASH_POLL_EN
        if (is_wr && poll_q) begin
          state_n = S_P_SETUP;
          cnt_n   = '0;
        end else
`endif
        begin
          state_n  = S_IDLE;
          inc_addr = autoinc_ena;
        end
      end
`ifdef FLASH_POLL_EN
      S_P_SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_n   = '0;
          state_n = S_P_STROBE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_P_STROBE: begin
        if (cnt == ACC_LAST) begin
          cnt_n        = '0;
          state_n      = S_P_CHECK;
          capture_poll = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_P_CHECK: begin
        // CS_n is high here, giving the flash the deselect it needs between status reads.
        if (poll_dq7 == wdata[7]) begin
          state_n  = S_IDLE;
          inc_addr = autoinc_ena;
        end else if (&tout_cnt) begin
          tout_set = 1'b1;
          state_n  = S_IDLE;
          inc_addr = autoinc_ena;
        end else begin
          tout_inc = 1'b1;
          state_n  = S_P_SETUP;
        end
      end
`endif
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase

    is_wr_n = accept_wr ? 1'b1 : (accept_rd ? 1'b0 : is_wr);

    // Strobes are decoded from the next state and registered, so no input reaches a pin combinationally.
    cs_act  = (state_n == S_SETUP) || (state_n == S_STROBE) || (state_n == S_HOLD) ||
              (state_n == S_P_SETUP) || (state_n == S_P_STROBE);
    oe_act  = ((state_n == S_STROBE) && !is_wr_n) || (state_n == S_P_STROBE);
    we_act  = (state_n == S_STROBE) && is_wr_n;
    drv_act = is_wr_n && ((state_n == S_SETUP) || (state_n == S_STROBE) || (state_n == S_HOLD));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr      <= '0;
      wdata     <= '0;
      is_wr     <= 1'b0;
      rd_buffer <= 8'hFF;
      rom_cs_n  <= 1'b1;
      rom_oe_n  <= 1'b1;
      rom_we_n  <= 1'b1;
      drive_en  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      is_wr <= is_wr_n;
      if (load_addr) begin
        addr <= {addr[AW-9:0], wr_buffer};
      end else if (inc_addr) begin
        addr <= addr + AW'(1);
      end
      if (accept_wr) begin
        wdata <= wr_buffer;
      end
      if (capture_rd) begin
        rd_buffer <= rom_d;
      end
      rom_cs_n <= ~cs_act;
      rom_oe_n <= ~oe_act;
      rom_we_n <= ~we_act;
      drive_en <= drv_act;
    end
  end

`ifdef FLASH_POLL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_q    <= 1'b0;
      poll_dq7  <= 1'b0;
      tout_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept_wr) begin
        poll_q <= poll_ena;
      end else if (accept_rd) begin
        poll_q <= 1'b0;
      end
      if (capture_poll) begin
        poll_dq7 <= rom_d[7];
      end
      if (accept_wr) begin
        tout_cnt <= '0;
      end else if (tout_inc) begin
        tout_cnt <= tout_cnt + TOUT_W'(1);
      end
      if (accept_wr || accept_rd) begin
        timeout_q <= 1'b0;
      end else if (tout_set) begin
        timeout_q <= 1'b1;
      end
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign busy      = (state != S_IDLE);
  assign rom_a     = addr;
  assign rom_d     = drive_en ? wdata : 8'bzzzz_zzzz;
  assign dbg_state = state;

endmodule

// File: doc/flash_seq.md
# flash_seq

Parametrised successor to the NeoGS flash-programmer ROM controller. It runs single-byte read and write cycles on the parallel flash chip. It is driven by strobe pulses and byte buffers from the zxbus controller, and sits between that controller and the flash pins. The block adds four things:
- configurable address width;
- configurable setup and strobe timing;
- a busy flag;
- optional DQ7 data-polling with a timeout after program writes.

## Interface
Parameters:
- AW, 19, flash address width in bits; minimum 9.
- SETUP_CYCLES, 1, cycles from address/CS valid to strobe fall; minimum 1.
- ACC_CYCLES, 3, cycles OE_n or WE_n is held low; minimum 1.
- TOUT_W, 20, width of the poll timeout counter.

Ports:
- clk  in  1  system clock (24 MHz domain).
- rst_n  in  1  reset; asynchronous assertion, active-low.
- wr_addr  in  1  one-cycle pulse: shift wr_buffer into the address register.
- wr_data  in  1  one-cycle pulse: write wr_buffer to flash at the current address.
- rd_data  in  1  one-cycle pulse: read flash at the current address into rd_buffer.
- wr_buffer  in  8  byte from the host.
- rd_buffer  out  8  last byte read from flash.
- autoinc_ena  in  1  increment the address after each completed access.
- poll_ena  in  1  after a write, DQ7-poll until complete.
- busy  out  1  an access is in progress; commands are ignored.
- timeout  out  1  sticky: the last poll expired.
- rom_a  out  AW  flash address.
- rom_d  inout  8  flash data bus; driven only during write cycles, otherwise Z.
- rom_cs_n, rom_oe_n, rom_we_n  out  1 each  flash strobes.

## Operation
Address register:
- On wr_addr, addr <= {addr[AW-9:0], wr_buffer}. The host therefore loads the MSB byte first; excess upper bits are discarded.

Command acceptance:
- Commands are accepted only in IDLE.
- Priority within one cycle is wr_addr > wr_data > rd_data; lower-priority pulses in the same cycle are dropped.
- All pulses that arrive while busy=1 are dropped.

FSM states: IDLE, SETUP, STROBE, HOLD, P_SETUP, P_STROBE, P_CHECK.
- Write path: IDLE → SETUP (CS low, wr_buffer latched and driven) → STROBE (WE_n low) → HOLD (1 cycle; CS low, WE_n high, data still driven) → IDLE, or → P_SETUP if poll_ena was sampled at acceptance.
- Read path: IDLE → SETUP (CS low) → STROBE (OE_n low; rom_d captured into rd_buffer on the last STROBE cycle) → HOLD → IDLE.
- Poll path:
  - P_SETUP, then P_STROBE (read at the same address), then P_CHECK.
  - In P_CHECK, if the read DQ7 equals bit 7 of the written byte, go to IDLE.
  - Otherwise, if the timeout counter has reached all-ones, set timeout and go to IDLE.
  - Otherwise, increment the counter and return to P_SETUP.
  - CS_n returns high for one cycle in P_CHECK; this produces the toggle the flash requires.

Timeout flag and counter:
- The timeout counter clears when a write is accepted.
- The timeout flag clears on any accepted wr_data or rd_data.

Auto-increment:
- Applied on the transition into IDLE after an access completes, including after polling and after a timeout, when autoinc_ena=1.
- The address wraps from 2^AW-1 to 0.

Other rules:
- wr_addr never starts a flash cycle.
- rom_a changes only in IDLE.

## Timing
Reset values:
- rom_cs_n=1, rom_oe_n=1, rom_we_n=1.
- rom_d=Z, rom_a=0.
- rd_buffer=8'hFF.
- busy=0, timeout=0, FSM=IDLE.

Asynchronous reset during any access deasserts all strobes and releases rom_d immediately; the in-flight access is lost.

Cycle timing:
- Command pulse sampled at edge N: busy=1 and rom_cs_n=0 from edge N+1.
- Non-polled access: busy=1 for exactly SETUP_CYCLES+ACC_CYCLES+1 cycles.
- rd_buffer is valid the cycle busy falls.
- Each poll iteration lasts SETUP_CYCLES+ACC_CYCLES+1 cycles.
- Worst-case poll duration is 2^TOUT_W iterations.
- rom_d is driven from the first SETUP cycle through the last HOLD cycle of a write only; it is never driven while rom_oe_n=0.
- All strobe outputs are registered; no combinational path from inputs to strobes.

## Configuration
FLASH_POLL_EN:
- Defined: the poll states, timeout counter and timeout flag are built as described.
- Undefined:
  - The poll states and counter are removed.
  - poll_ena is ignored.
  - timeout is tied to 0.
  - Writes always end HOLD → IDLE.

## Test plan
- Reset, then three wr_addr pulses with 0x01, 0x23, 0x45 (AW=19) → rom_a=0x12345 (top bits truncated); strobes stay high.
- rd_data with flash model returning 0xA5, defaults → busy high 5 cycles; OE_n low 3 cycles; rd_buffer=0xA5 when busy falls; autoinc_ena=1 gives rom_a+1.
- wr_data 0x5A, poll_ena=0 → WE_n low 3 cycles; rom_d=0x5A from the first SETUP through HOLD; Z afterwards.
- FLASH_POLL_EN, wr_data 0x80, model returns DQ7=0 for 4 polls then 1 → exactly 5 poll reads; busy then falls; timeout=0.
- FLASH_POLL_EN, TOUT_W=3, model never completes → 8 poll iterations; timeout=1; next rd_data clears it.
- Address at 0x7FFFF with autoinc, a wr_data issued while busy, and rst_n asserted during STROBE → address wraps to 0; the second write is dropped; strobes go high asynchronously on reset.
